mem_access_unit: RTL

MEM-stage load/store sequencer that sits directly upstream of the data memory (64-bit words, single-word or single-byte write enables, combinational read).
- Accepts one load or store request at a time, of size byte, half, word or dword.
- Stores that are not aligned dwords are broken into per-byte writes; loads are extracted and extended from the 64-bit read word.
- Stalls the pipeline via req_ready and signals completion with a one-cycle resp_valid.

---
 rtl/mem_access_unit.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage load/store sequencer in front of a 64-bit data memory with a
// combinational read port and word/byte write enables.
module mem_access_unit #(
  parameter logic [63:0] DATA_START = 64'h1000_0000_0000_0000,
  parameter int unsigned DATA_WORDS = 'h100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [63:0] resp_rdata,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic        mem_word_we,
  output logic        mem_byte_we,
  input  logic [63:0] mem_rdata
);

  // One bit wider than an address so the end bound cannot wrap.
  localparam logic [64:0] DATA_END = {1'b0, DATA_START} + 65'(DATA_WORDS) * 65'd8;

  typedef enum logic [1:0] {IDLE, LOAD, STORE_W, STORE_B} state_t;

  state_t      state_q, state_d;
  logic [63:0] a_addr_q, a_addr_d;
  logic [1:0]  a_size_q, a_size_d;
  logic        a_signed_q, a_signed_d;
  logic [63:0] a_wdata_q, a_wdata_d;
  logic        a_err_q, a_err_d;
  logic [2:0]  idx_q, idx_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic [63:0] resp_rdata_q, resp_rdata_d;
  logic [63:0] mem_addr_q, mem_addr_d;
  logic [63:0] mem_wdata_q, mem_wdata_d;
  logic        mem_word_we_q, mem_word_we_d;
  logic        mem_byte_we_q, mem_byte_we_d;

  logic [64:0] req_end;
  logic [2:0]  req_mask;
  logic        req_oor;
  logic        req_mis;
  logic        req_err;
  logic [2:0]  last_idx;

  // Shift the addressed lane down, truncate to the access size, then extend.
  function automatic logic [63:0] load_extend(input logic [63:0] rdata,
                                              input logic [2:0]  ofs,
                                              input logic [1:0]  size,
                                              input logic        sgn);
    logic [63:0] sh;
    sh = rdata >> {ofs, 3'b000};
    case (size)
      2'd0:    return {{56{sgn & sh[7]}}, sh[7:0]};
      2'd1:    return {{48{sgn & sh[15]}}, sh[15:0]};
      2'd2:    return {{32{sgn & sh[31]}}, sh[31:0]};
      default: return sh;
    endcase
  endfunction

  function automatic logic [7:0] store_byte(input logic [63:0] wdata,
                                            input logic [2:0]  i);
    return wdata[{i, 3'b000} +: 8];
  endfunction

  always_comb begin
    req_mask = 3'((4'd1 << req_size) - 4'd1);
    req_end  = {1'b0, req_addr} + 65'(4'd1 << req_size);
    req_oor  = (req_addr < DATA_START) || (req_end > DATA_END);
    req_mis  = (req_addr[2:0] & req_mask) != 3'd0;
    req_err  = req_oor || (!req_write && req_mis);
    last_idx = 3'((4'd1 << a_size_q) - 4'd1);
  end

  always_comb begin
    state_d       = state_q;
    a_addr_d      = a_addr_q;
    a_size_d      = a_size_q;
    a_signed_d    = a_signed_q;
    a_wdata_d     = a_wdata_q;
    a_err_d       = a_err_q;
    idx_d         = idx_q;
    resp_valid_d  = 1'b0;
    resp_err_d    = 1'b0;
    resp_rdata_d  = resp_rdata_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_word_we_d = 1'b0;
    mem_byte_we_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          a_addr_d   = req_addr;
          a_size_d   = req_size;
          a_signed_d = req_signed;
          a_wdata_d  = req_wdata;
          a_err_d    = req_err;
          mem_addr_d = req_addr;
          idx_d      = 3'd0;
          // Faulting stores go through LOAD so they never raise a write enable.
          if (req_err || !req_write) begin
            state_d = LOAD;
          end else if (req_size == 2'd3 && req_addr[2:0] == 3'd0) begin
            state_d       = STORE_W;
            mem_wdata_d   = req_wdata;
            mem_word_we_d = 1'b1;
          end else begin
            state_d       = STORE_B;
            mem_wdata_d   = {56'b0, req_wdata[7:0]};
            mem_byte_we_d = 1'b1;
          end
        end
      end

      LOAD: begin
        state_d      = IDLE;
        resp_valid_d = 1'b1;
        resp_err_d   = a_err_q;
        resp_rdata_d = a_err_q ? 64'd0
                               : load_extend(mem_rdata, a_addr_q[2:0], a_size_q, a_signed_q);
      end

      STORE_W: begin
        state_d      = IDLE;
        resp_valid_d = 1'b1;
        resp_rdata_d = 64'd0;
      end

      STORE_B: begin
        if (idx_q == last_idx) begin
          state_d      = IDLE;
          resp_valid_d = 1'b1;
          resp_rdata_d = 64'd0;
        end else begin
          idx_d         = idx_q + 3'd1;
          mem_addr_d    = a_addr_q + 64'(idx_q + 3'd1);
          mem_wdata_d   = {56'b0, store_byte(a_wdata_q, idx_q + 3'd1)};
          mem_byte_we_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      a_addr_q      <= 64'd0;
      a_size_q      <= 2'd0;
      a_signed_q    <= 1'b0;
      a_wdata_q     <= 64'd0;
      a_err_q       <= 1'b0;
      idx_q         <= 3'd0;
      resp_valid_q  <= 1'b0;
      resp_err_q    <= 1'b0;
      resp_rdata_q  <= 64'd0;
      mem_addr_q    <= 64'd0;
      mem_wdata_q   <= 64'd0;
      mem_word_we_q <= 1'b0;
      mem_byte_we_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      a_addr_q      <= a_addr_d;
      a_size_q      <= a_size_d;
      a_signed_q    <= a_signed_d;
      a_wdata_q     <= a_wdata_d;
      a_err_q       <= a_err_d;
      idx_q         <= idx_d;
      resp_valid_q  <= resp_valid_d;
      resp_err_q    <= resp_err_d;
      resp_rdata_q  <= resp_rdata_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_word_we_q <= mem_word_we_d;
      mem_byte_we_q <= mem_byte_we_d;
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign resp_valid  = resp_valid_q;
  assign resp_err    = resp_err_q;
  assign resp_rdata  = resp_rdata_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_word_we = mem_word_we_q;
  assign mem_byte_we = mem_byte_we_q;

endmodule
